apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns single-beat commands from a local controller into APB transfers on the bus and returns each transfer's result as a one-cycle response pulse. It drives psel/penable/paddr/pwrite/pwdata and samples pready/prdata. It sits between the system controller or testbench driver and one or more APB completers on the same pclk domain. A wait-state timer aborts any access that a completer never finishes.

## Interface
Parameters:
- ADDR_W, 8, width of paddr and cmd_addr
- DATA_W, 8, width of pwdata/prdata and command/response data
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout (wait forever)

Ports:
- pclk  in  1  bus clock; all logic is on its rising edge
- presetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted; equals (state == IDLE)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse when a transfer ends
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: the transfer was aborted
- busy  out  1  high in SETUP or ACCESS
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready  in  1  completer ready
- prdata  in  DATA_W  completer read data

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- IDLE:
  - cmd_ready=1.
  - If cmd_valid is high at an edge: capture cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP: psel=1, penable=0. Always advances to ACCESS after one cycle.
- ACCESS:
  - psel=1, penable=1.
  - If pready is high at an edge, the transfer completes. On a read, prdata is captured into rsp_rdata. rsp_valid=1 with rsp_timeout=0 for the next cycle, and the FSM goes to IDLE.
- Timeout:
  - wait_cnt clears on entry to ACCESS and increments each ACCESS cycle in which pready is low.
  - If TIMEOUT>0 and the TIMEOUT-th ACCESS cycle ends with pready low, the transfer aborts. rsp_valid=1, rsp_timeout=1 and rsp_rdata=0 for the next cycle, and the FSM goes to IDLE.
  - pready high on the TIMEOUT-th cycle counts as a normal completion, not an abort.
- Signals while not in SETUP or ACCESS:
  - psel and penable are 0.
  - paddr, pwrite and pwdata hold their last values and change only on command acceptance.
- rsp_rdata holds its value between responses. rsp_valid and rsp_timeout are single-cycle pulses.
- There is no response back-pressure. The consumer must accept rsp_valid in the cycle it is asserted.
- Reset (asynchronous, any state including mid-transfer):
  - state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, wait_cnt=0.
  - cmd_ready=1 and busy=0 follow from IDLE.
  - An in-flight transfer is dropped with no response.

## Timing
- Edge 0: accept. Cycle 1: SETUP. Cycle 2 onward: ACCESS.
- Zero-wait completion at the end of cycle 2, with rsp_valid in cycle 3.
- Minimum command-to-response latency is 3 cycles. Each completer wait state adds 1.
- Maximum throughput is one transfer per 3 cycles.
  - cmd_ready is high in the response cycle, since the FSM is back in IDLE.
  - A command held valid is accepted on that edge, so the rsp_valid cycle overlaps the next command's acceptance.
- Timeout response arrives 2+TIMEOUT cycles after acceptance.
- cmd_valid asserted outside IDLE has no effect. The controller must hold it until it sees cmd_ready.

## Structure
- Package apb_pkg holds the state enum (IDLE, SETUP, ACCESS) and default ADDR_W/DATA_W constants shared with the APB completer.
- Sub-module apb_wait_timer holds the wait_cnt counter. Its ports are: clear, enable, a TIMEOUT parameter, and an expired output. The counter width is $clog2(TIMEOUT+1).
- The FSM and output registers live in apb_master.

## Test plan
- Write, zero wait:
  - Stimulus: cmd write addr=0x03 wdata=0xA5, completer pready=1 in ACCESS.
  - Required: psel rises cycle 1, penable cycle 2 with paddr=0x03, pwdata=0xA5, pwrite=1; rsp_valid=1, rsp_timeout=0 in cycle 3.
- Read, two wait states:
  - Stimulus: cmd read addr=0x05, pready low for 2 ACCESS cycles, prdata=0x3C on the third.
  - Required: penable high 3 cycles; rsp_valid with rsp_rdata=0x3C in cycle 5.
- Back-to-back:
  - Stimulus: cmd_valid held with write 0x01=0x11, then read 0x01, completer returning 0x11.
  - Required: second psel rises exactly 3 cycles after the first; read response rsp_rdata=0x11.
- Timeout, TIMEOUT=4:
  - Stimulus: pready held 0.
  - Required: 4 ACCESS cycles, then rsp_valid=1, rsp_timeout=1, rsp_rdata=0, psel=0.
- Timeout boundary:
  - Stimulus: pready=1 on ACCESS cycle 4 with TIMEOUT=4.
  - Required: normal completion, rsp_timeout=0.
- Mid-transfer reset:
  - Stimulus: presetn pulled low during ACCESS.
  - Required: psel/penable 0 immediately; no rsp_valid; cmd_ready=1 after release; next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding and default bus widths.
// Also used by the APB completer models on the same pclk domain.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states.
// Flags the wait state that would exceed the TIMEOUT budget.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] wait_cnt;

    // The count equals the number of ACCESS cycles already spent waiting,
    // so LAST marks the TIMEOUT-th cycle.
    assign expired = (TIMEOUT > 0) && enable && (wait_cnt == LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && !expired) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: single-beat commands in, APB transfers out.
// Each transfer ends in a one-cycle response pulse, optionally flagged as a timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    apb_state_e state, state_n;
    logic       expired;
    logic       accept;
    logic       in_setup;
    logic       waiting;

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (in_setup),
        .enable  (waiting),
        .expired (expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        in_setup  = 1'b0;
        waiting   = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_n = SETUP;
            end
            SETUP: begin
                psel     = 1'b1;
                in_setup = 1'b1;
                state_n  = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                waiting = !pready;
                if (pready || expired) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy   = psel;
    assign accept = cmd_ready && cmd_valid;

    // Bus address/data only move on acceptance so they stay stable when idle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (accept) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            if (penable && pready) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= pwrite ? '0 : prdata;
            end else if (penable && expired) begin
                rsp_valid   <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus randomized transfers
// checked against a latency/memory reference model.
module tb_apb_master;

    localparam int TO = 4;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic       busy;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pready;
    logic [7:0] prdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] comp_mem [256];
    logic [7:0] ref_mem [256];
    int         wait_plan = 0;
    int         acc_cnt = 0;

    apb_master #(
        .ADDR_W(8),
        .DATA_W(8),
        .TIMEOUT(TO)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata)
    );

    always #5 pclk = ~pclk;

    // Completer: inserts wait_plan wait states, then completes.
    assign pready = psel && penable && (acc_cnt >= wait_plan);
    assign prdata = comp_mem[paddr];

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready && pwrite) comp_mem[paddr] <= pwdata;
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic run_xfer(input logic w, input logic [7:0] a,
                            input logic [7:0] d, input int waits);
        int cyc;
        int pen;
        int exp_lat;
        int exp_pen;
        logic exp_to;
        logic [7:0] exp_rd;
        exp_to  = (waits >= TO);
        exp_lat = exp_to ? 2 + TO : 3 + waits;
        exp_pen = exp_to ? TO : waits + 1;
        exp_rd  = (!w && !exp_to) ? ref_mem[a] : 8'h00;
        if (w && !exp_to) ref_mem[a] = d;
        wait_plan = waits;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_before: got %0b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL setup_phase: got psel=%0b penable=%0b busy=%0b want 1 0 1",
                     psel, penable, busy);
        end
        checks++;
        if (paddr !== a || pwrite !== w || (w && pwdata !== d)) begin
            failures++;
            $display("FAIL bus_fields: got a=%0h w=%0b d=%0h want a=%0h w=%0b d=%0h",
                     paddr, pwrite, pwdata, a, w, d);
        end
        cyc = 1;
        pen = 0;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            if (penable) pen++;
            @(posedge pclk);
            #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("penable_cycles", pen, exp_pen);
        chk("rsp_timeout", int'(rsp_timeout), int'(exp_to));
        chk("rsp_rdata", int'(rsp_rdata), int'(exp_rd));
        chk("rsp_psel_low", int'(psel), 0);
        chk("rsp_cmd_ready", int'(cmd_ready), 1);
        @(posedge pclk);
        #1;
        chk("rsp_pulse", int'(rsp_valid), 0);
        chk("rdata_hold", int'(rsp_rdata), int'(exp_rd));
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        #2;
        chk("rst_psel", int'(psel), 0);
        chk("rst_penable", int'(penable), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_paddr", int'(paddr), 0);
        chk("rst_pwdata", int'(pwdata), 0);
        chk("rst_pwrite", int'(pwrite), 0);
        chk("rst_rsp", int'({rsp_valid, rsp_timeout}), 0);
        chk("rst_rdata", int'(rsp_rdata), 0);
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    task automatic test_write_zero();
        run_xfer(1'b1, 8'h03, 8'hA5, 0);
    endtask

    task automatic test_read_wait();
        comp_mem[8'h05] = 8'h3C;
        ref_mem[8'h05]  = 8'h3C;
        run_xfer(1'b0, 8'h05, 8'h00, 2);
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 8'h07, 8'h00, 100);
    endtask

    task automatic test_timeout_boundary();
        run_xfer(1'b1, 8'h09, 8'h5A, TO - 1);
    endtask

    task automatic test_back_to_back();
        int t;
        int rise2;
        wait_plan = 0;
        ref_mem[8'h01] = 8'h11;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h01;
        cmd_wdata = 8'h11;
        @(posedge pclk);
        #1;
        cmd_write = 1'b0;
        cmd_wdata = 8'h00;
        t = 1;
        rise2 = 0;
        while (rise2 == 0 && t < 20) begin
            @(posedge pclk);
            #1;
            t++;
            if (psel && !penable && t > 1) rise2 = t;
        end
        cmd_valid = 1'b0;
        chk("b2b_second_psel", rise2 - 1, 3);
        chk("b2b_addr", int'(paddr), 8'h01);
        chk("b2b_dir", int'(pwrite), 0);
        t = 0;
        while (rsp_valid !== 1'b1 && t < 20) begin
            @(posedge pclk);
            #1;
            t++;
        end
        chk("b2b_read_lat", t, 2);
        chk("b2b_rdata", int'(rsp_rdata), int'(ref_mem[8'h01]));
        @(posedge pclk);
        #1;
    endtask

    task automatic test_mid_reset();
        wait_plan = 10;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h20;
        cmd_wdata = 8'hEE;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        chk("mid_in_access", int'(penable), 1);
        presetn = 1'b0;
        #1;
        chk("mid_psel", int'(psel), 0);
        chk("mid_penable", int'(penable), 0);
        @(posedge pclk);
        #1;
        chk("mid_no_rsp", int'(rsp_valid), 0);
        presetn = 1'b1;
        @(posedge pclk);
        #1;
        chk("mid_no_rsp2", int'(rsp_valid), 0);
        chk("mid_ready", int'(cmd_ready), 1);
        run_xfer(1'b0, 8'h03, 8'h00, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                     8'($urandom), $urandom_range(0, TO + 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            comp_mem[i] = 8'($urandom);
            ref_mem[i]  = comp_mem[i];
        end
        test_reset();
        test_write_zero();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_timeout_boundary();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
